lfsr8_checker: RTL and testbench
================================

Name: lfsr8_checker

Overview:
- Receive end of the 8-bit LFSR pseudo-random stream: consumes one 8-bit LFSR state per valid cycle and checks it against its own locally predicted next state.
- Self-synchronising: seeds from the incoming stream, declares lock after a run of matches, then counts errors while locked.
- Placed downstream of LFSR8bit, or of any link carrying its output, as a built-in self-test monitor.

Parameters:
- TAPS, 8'hB8, feedback tap mask (bits 7,5,4,3 = x^8+x^6+x^5+x^4+1, maximal length 255).
- LOCK_CNT, 4, consecutive matches after seeding required to declare lock (range 1..15).
- LOSS_CNT, 3, consecutive mismatches while locked that drop lock (range 1..15).
- CNT_W, 16, width of err_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a new LFSR sample this cycle.
- in_data  input  8  received LFSR state.
- clear_cnt  input  1  synchronous clear of err_count.
- locked  output  1  checker is in LOCKED state.
- err_pulse  output  1  one-cycle pulse per mismatched sample while locked.
- err_count  output  CNT_W  saturating count of locked mismatches.
- expected  output  8  checker's prediction for the next valid sample.

Behaviour:
- next(q) = {q[6:0], ^(q & TAPS)}. Fibonacci form, shift toward MSB.
- Reset (async, rst=1):
  - state=SEARCH, expected=0, match_cnt=0, miss_cnt=0.
  - locked=0, err_pulse=0, err_count=0.
- All outputs are registered and update on the clk edge where in_valid=1 is sampled.
- in_valid=0: no state or counter changes; err_pulse=0.
- err_pulse is 0 on every cycle except those specified below.
- SEARCH:
  - valid, in_data!=0: expected<=next(in_data), match_cnt<=0, go VERIFY.
  - valid, in_data==0 (lock-up value): ignored, stay SEARCH.
- VERIFY:
  - valid, in_data==expected: expected<=next(in_data), match_cnt++.
  - If match_cnt+1==LOCK_CNT on a match: go LOCKED, locked<=1, miss_cnt<=0.
  - Mismatch, in_data!=0: reseed, expected<=next(in_data), match_cnt<=0, stay VERIFY.
  - Mismatch, in_data==0: go SEARCH.
  - No errors are counted and err_pulse stays 0 in VERIFY.
- LOCKED (flywheel):
  - valid: expected<=next(expected) always; the checker never reseeds from data.
  - Match: miss_cnt<=0.
  - Mismatch: err_pulse<=1 for one cycle, err_count++ (saturates at all-ones), miss_cnt++.
  - If miss_cnt+1==LOSS_CNT on a mismatch: go SEARCH, locked<=0, match_cnt<=0.
- clear_cnt=1: err_count<=0. Clear has priority over a simultaneous increment, so the result is 0; err_pulse still asserts for that error.
- A sample equal to 0 while LOCKED is an ordinary mismatch.
- Timing:
  - First nonzero sample seeds; lock asserts on the edge of the (LOCK_CNT+1)th consecutive good sample.
  - With defaults, locked rises on the clock edge that samples the 5th good sample.
- Reset mid-operation: immediate return to the reset state; counts are lost.
- Back-to-back valid every cycle is supported; there is no backpressure.

Decomposition:
- Shared package lfsr_pkg:
  - LFSR_W=8, TAPS_DEFAULT=8'hB8.
  - State enum {SEARCH, VERIFY, LOCKED}.
  - Function lfsr_next(q, taps). LFSR8bit should use the same function so generator and checker share one polynomial definition.
- Optional sub-module sat_counter (parameterised width, inc, clr, clr-priority) for err_count; everything else stays in lfsr8_checker.

Test Plan:
- Clean lock: after reset, feed 01,02,04,08,11 one per cycle with in_valid=1. Required: locked=0 through the 4th sample, locked=1 after the 5th, expected=next(11), err_count=0.
- Full period: feed 300 consecutive generator outputs from seed 01. Required: locked stays 1 after lock, err_pulse never asserts, and the sequence repeats after 255 samples.
- Single error while locked: corrupt one sample (xor 8'h40). Required: one err_pulse, err_count=1, locked stays 1, and the next correct sample matches because of the flywheel.
- Loss of lock: while locked, feed 3 consecutive wrong samples. Required: 3 err_pulses, err_count=3, locked=0 after the 3rd. A subsequent good stream relocks after 5 samples.
- Zero handling and gaps:
  - After reset, feed 00 then 00 (stays SEARCH, no pulse), then a valid stream with in_valid=0 gaps inserted. Required: lock timing counts only valid samples.
  - A 00 sample during VERIFY returns the checker to SEARCH.
- Clear and async reset: assert clear_cnt in the same cycle as an error. Required: err_count=0 and err_pulse=1. Assert rst mid-stream between clock edges. Required: locked=0 and err_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR width, polynomial, checker states and next-state function
package lfsr_pkg;

  localparam int              LFSR_W       = 8;
  localparam logic [LFSR_W-1:0] TAPS_DEFAULT = 8'hB8;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_t;

  // Fibonacci step: shift toward the MSB, parity of the tapped bits enters at bit 0
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q,
                                                  input logic [LFSR_W-1:0] taps);
    return {q[LFSR_W-2:0], ^(q & taps)};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear taking priority over increment
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // clear wins; otherwise count up and hold at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/lfsr8_checker.sv
// rtl/lfsr8_checker.sv - self-synchronising receive-side checker for the 8-bit LFSR stream
module lfsr8_checker
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] TAPS     = TAPS_DEFAULT,
  parameter int                LOCK_CNT = 4,
  parameter int                LOSS_CNT = 3,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_data,
  input  logic              clear_cnt,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  output logic [LFSR_W-1:0] expected
);

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

  lfsr_state_t       state;
  logic [3:0]        match_cnt;
  logic [3:0]        miss_cnt;
  logic              data_zero;
  logic              data_hit;
  logic              err_inc;

  assign data_zero = (in_data == '0);
  assign data_hit  = (in_data == expected);
  assign err_inc   = in_valid && (state == LOCKED) && !data_hit;

  // acquisition (seed, verify run) and flywheel tracking once locked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      expected  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        unique case (state)
          SEARCH: begin
            // all-zero is the lock-up value and can never seed a valid stream
            if (!data_zero) begin
              expected  <= lfsr_next(in_data, TAPS);
              match_cnt <= '0;
              state     <= VERIFY;
            end
          end
          VERIFY: begin
            if (data_hit) begin
              expected  <= lfsr_next(in_data, TAPS);
              match_cnt <= match_cnt + 4'd1;
              if (match_cnt + 4'd1 == LOCK_TGT) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end else if (!data_zero) begin
              expected  <= lfsr_next(in_data, TAPS);
              match_cnt <= '0;
            end else begin
              state <= SEARCH;
            end
          end
          LOCKED: begin
            // never reseed from data here, so a single bad sample cannot derail the prediction
            expected <= lfsr_next(expected, TAPS);
            if (data_hit) begin
              miss_cnt <= '0;
            end else begin
              err_pulse <= 1'b1;
              miss_cnt  <= miss_cnt + 4'd1;
              if (miss_cnt + 4'd1 == LOSS_TGT) begin
                state     <= SEARCH;
                locked    <= 1'b0;
                match_cnt <= '0;
              end
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .clr   (clear_cnt),
    .count (err_count)
  );

endmodule

// File: tb/tb_lfsr8_checker.sv
// tb/tb_lfsr8_checker.sv - randomized self-checking bench for lfsr8_checker
module tb_lfsr8_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        clear_cnt;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [7:0]  expected;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: acquisition phase flags, run lengths and plain integer values
  bit    m_seeded;
  bit    m_locked;
  bit    m_pulse;
  int    m_run;
  int    m_miss;
  int    m_exp;
  int    m_errs;

  int    g;
  int    pulses;
  string phase;

  always #5 clk = ~clk;

  lfsr8_checker dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .expected  (expected)
  );

  function automatic int nx(int q);
    int fb;
    fb = ((q >> 7) + (q >> 5) + (q >> 4) + (q >> 3)) % 2;
    return ((q * 2) % 256) + fb;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_seeded = 0; m_locked = 0; m_pulse = 0;
    m_run = 0; m_miss = 0; m_exp = 0; m_errs = 0;
  endtask

  task automatic model_step(bit v, int d, bit c);
    bit hit;
    m_pulse = 0;
    if (v) begin
      if (m_locked) begin
        hit   = (d == m_exp);
        m_exp = nx(m_exp);
        if (hit) m_miss = 0;
        else begin
          m_pulse = 1;
          if (m_errs < 65535) m_errs++;
          m_miss++;
          if (m_miss == 3) begin
            m_locked = 0; m_seeded = 0; m_run = 0;
          end
        end
      end else if (!m_seeded) begin
        if (d != 0) begin
          m_exp = nx(d); m_run = 0; m_seeded = 1;
        end
      end else begin
        if (d == m_exp) begin
          m_exp = nx(d);
          m_run++;
          if (m_run == 4) begin
            m_locked = 1; m_miss = 0;
          end
        end else if (d != 0) begin
          m_exp = nx(d); m_run = 0;
        end else begin
          m_seeded = 0;
        end
      end
    end
    if (c) m_errs = 0;
  endtask

  task automatic check_all();
    check({phase, ".locked"},    32'(locked),    32'(m_locked));
    check({phase, ".err_pulse"}, 32'(err_pulse), 32'(m_pulse));
    check({phase, ".err_count"}, 32'(err_count), 32'(m_errs));
    check({phase, ".expected"},  32'(expected),  32'(m_exp));
  endtask

  task automatic cyc(bit v, int d, bit c);
    in_valid  = v;
    in_data   = 8'(d);
    clear_cnt = c;
    @(posedge clk);
    model_step(v, d, c);
    #1;
    if (err_pulse === 1'b1) pulses++;
    check_all();
  endtask

  // drive the next generator output and advance the generator
  task automatic good();
    cyc(1, g, 0);
    g = nx(g);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 0; in_data = 0; clear_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int exp_at[$];
    bit v;
    int r;
    int d;
    bit c;

    rst = 1'b1;
    in_valid = 0; in_data = 0; clear_cnt = 0;
    model_reset();
    #2;
    phase = "reset";
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // clean lock from 01
    phase = "clean_lock";
    g = 1;
    for (int k = 1; k <= 5; k++) begin
      good();
      if (k == 4) check("clean_lock.locked_4th", 32'(locked), 32'd0);
    end
    check("clean_lock.locked_5th", 32'(locked), 32'd1);
    check("clean_lock.expected_23", 32'(expected), 32'h23);
    check("clean_lock.err_count0", 32'(err_count), 32'd0);

    // full period: prediction repeats every 255 samples, no errors
    phase = "period";
    pulses = 0;
    for (int k = 0; k < 300; k++) begin
      good();
      exp_at.push_back(int'(expected));
    end
    for (int k = 0; k < 45; k += 11)
      check("period.repeat255", 32'(exp_at[k + 255]), 32'(exp_at[k]));
    check("period.no_pulse", 32'(pulses), 32'd0);
    check("period.locked", 32'(locked), 32'd1);

    // single corrupted sample, flywheel carries on
    phase = "single_err";
    cyc(1, g ^ 8'h40, 0);
    g = nx(g);
    check("single_err.pulse", 32'(err_pulse), 32'd1);
    check("single_err.count", 32'(err_count), 32'd1);
    check("single_err.locked", 32'(locked), 32'd1);
    good();
    check("single_err.next_ok", 32'(err_pulse), 32'd0);

    // loss of lock after three misses, then relock
    phase = "loss";
    cyc(1, g, 1);
    g = nx(g);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(1, g ^ 8'h01, 0);
      g = nx(g);
    end
    check("loss.pulses", 32'(pulses), 32'd3);
    check("loss.count", 32'(err_count), 32'd3);
    check("loss.unlocked", 32'(locked), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      good();
      if (k == 4) check("loss.relock_4th", 32'(locked), 32'd0);
    end
    check("loss.relock_5th", 32'(locked), 32'd1);

    // zeros in SEARCH, gaps between valid samples
    phase = "zero_gap";
    do_reset();
    pulses = 0;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("zero_gap.search_pulse", 32'(pulses), 32'd0);
    g = 8'h5A;
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 8'hFF, 0);
      cyc(0, 8'h00, 0);
      good();
      if (k == 4) check("zero_gap.locked_4th", 32'(locked), 32'd0);
    end
    check("zero_gap.locked_5th", 32'(locked), 32'd1);

    // zero during VERIFY returns to SEARCH: lock needs a fresh seed + 4
    phase = "zero_verify";
    do_reset();
    g = 8'h01;
    good();
    good();
    cyc(1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      good();
      if (k == 4) check("zero_verify.locked_4th", 32'(locked), 32'd0);
    end
    check("zero_verify.locked_5th", 32'(locked), 32'd1);

    // clear in the same cycle as an error
    phase = "clear_err";
    cyc(1, g ^ 8'h80, 0);
    g = nx(g);
    cyc(1, g ^ 8'h80, 1);
    g = nx(g);
    check("clear_err.pulse", 32'(err_pulse), 32'd1);
    check("clear_err.count", 32'(err_count), 32'd0);
    good();

    // randomized traffic: gaps, corruptions, zeros, stream jumps, clears
    phase = "random";
    for (int k = 0; k < 3000; k++) begin
      v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      if (r < 4)       d = 0;
      else if (r < 12) d = g ^ (1 << $urandom_range(0, 7));
      else if (r < 14) begin g = $urandom_range(1, 255); d = g; end
      else             d = g;
      c = v && ($urandom_range(0, 49) == 0);
      cyc(v, d, c);
      if (v) g = nx(g);
    end

    // async reset between edges while locked with a nonzero count
    phase = "async_rst";
    for (int k = 0; k < 6; k++) good();
    cyc(1, g ^ 8'h10, 0);
    g = nx(g);
    check("async_rst.pre_locked", 32'(locked), 32'd1);
    check("async_rst.pre_count_nz", 32'(err_count != 0), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst.locked", 32'(locked), 32'd0);
    check("async_rst.count", 32'(err_count), 32'd0);
    check("async_rst.expected", 32'(expected), 32'd0);
    #1;
    rst = 1'b0;
    cyc(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
